// File: rtl/enoc_alloc_pkg.sv
// Shared types and helpers for the ENoC switch allocator.
// Port index constants, per-output FSM state and pointer-width helper.
package enoc_alloc_pkg;

    localparam int unsigned C = 0;
    localparam int unsigned N = 1;
    localparam int unsigned E = 2;
    localparam int unsigned S = 3;
    localparam int unsigned W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_e;

    // Ceiling log2, never below 1 so that index registers keep a legal width.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/enoc_switch_allocator_if.sv
// Request/grant bundle between the input ports, output ports and the switch allocator.
interface enoc_switch_allocator_if #(
    parameter int unsigned N_PORTS = 5
);
    logic [0:N_PORTS-1][0:N_PORTS-1] i_output_req;
    logic [0:N_PORTS-1]              i_tail;
    logic [0:N_PORTS-1]              i_en;
    logic [0:N_PORTS-1]              o_input_grant;
    logic [0:N_PORTS-1][0:N_PORTS-1] o_output_sel;
    logic [0:N_PORTS-1]              o_output_val;

    modport master (
        output i_output_req, i_tail, i_en,
        input  o_input_grant, o_output_sel, o_output_val
    );

    modport slave (
        input  i_output_req, i_tail, i_en,
        output o_input_grant, o_output_sel, o_output_val
    );
endinterface

// File: rtl/enoc_rr_arbiter.sv
// Combinational cyclic priority search: first requester at or after ptr wins.
module enoc_rr_arbiter
    import enoc_alloc_pkg::*;
#(
    parameter  int unsigned N_PORTS = 5,
    localparam int unsigned PTR_W   = log2(N_PORTS)
) (
    input  logic [0:N_PORTS-1] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [0:N_PORTS-1] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    always_comb begin
        int unsigned idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            idx = (32'(ptr) + k) % N_PORTS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner     = PTR_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enoc_switch_allocator.sv
// Per-router switch allocator: one round-robin arbiter and wormhole lock per output.
// Grants are combinational; pointers and locks update on the granting edge.
module enoc_switch_allocator
    import enoc_alloc_pkg::*;
#(
    parameter int unsigned N_PORTS = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    enoc_switch_allocator_if.slave   bus
);

    localparam int unsigned PTR_W = log2(N_PORTS);

    logic [0:N_PORTS-1] req_ok;
    logic [0:N_PORTS-1] out_sel [N_PORTS];

    // Multi-hot request vectors are treated as no request.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            req_ok[i] = $onehot(bus.i_output_req[i]);
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_out
        logic [0:N_PORTS-1] req_vec;
        logic [0:N_PORTS-1] arb_grant;
        logic [0:N_PORTS-1] sel;
        logic [PTR_W-1:0]   arb_winner;
        logic               arb_found;
        logic [PTR_W-1:0]   ptr_q, ptr_d;
        logic [PTR_W-1:0]   owner_q, owner_d;
        alloc_state_e       state_q, state_d;

        always_comb begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                req_vec[i] = req_ok[i] & bus.i_output_req[i][o];
            end
        end

        enoc_rr_arbiter #(
            .N_PORTS (N_PORTS)
        ) u_arb (
            .req    (req_vec),
            .ptr    (ptr_q),
            .grant  (arb_grant),
            .winner (arb_winner),
            .found  (arb_found)
        );

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                owner_q <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                owner_q <= owner_d;
            end
        end

        // Next state and grant; everything is held and nothing granted while in reset.
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            owner_d = owner_q;
            sel     = '0;
            if (reset_n) begin
                case (state_q)
                    IDLE: begin
                        if (arb_found && bus.i_en[o]) begin
                            sel   = arb_grant;
                            ptr_d = (32'(arb_winner) == N_PORTS - 1) ? '0
                                                                      : PTR_W'(arb_winner + 1'b1);
                            if (!bus.i_tail[arb_winner]) begin
                                state_d = LOCKED;
                                owner_d = arb_winner;
                            end
                        end
                    end
                    LOCKED: begin
                        if (req_vec[owner_q] && bus.i_en[o]) begin
                            sel[owner_q] = 1'b1;
                            if (bus.i_tail[owner_q]) begin
                                state_d = IDLE;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        assign out_sel[o] = sel;
    end

    always_comb begin
        bus.o_input_grant = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            bus.o_output_sel[o] = out_sel[o];
            bus.o_output_val[o] = |out_sel[o];
            bus.o_input_grant   = bus.o_input_grant | out_sel[o];
        end
    end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Scoreboard bench for enoc_switch_allocator: directed vectors with hand-computed winners.
module tb_enoc_switch_allocator;

    localparam int unsigned NP = 5;

    localparam logic [0:NP-1] NO  = 5'b00000;
    localparam logic [0:NP-1] O0  = 5'b10000;
    localparam logic [0:NP-1] O1  = 5'b01000;
    localparam logic [0:NP-1] O2  = 5'b00100;
    localparam logic [0:NP-1] O3  = 5'b00010;
    localparam logic [0:NP-1] O4  = 5'b00001;
    localparam logic [0:NP-1] ALL = 5'b11111;

    typedef struct {
        logic [0:NP-1]         grant;
        logic [0:NP-1][0:NP-1] sel;
        logic [0:NP-1]         val;
        string                 name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    enoc_switch_allocator_if #(.N_PORTS(NP)) bus ();

    enoc_switch_allocator #(
        .N_PORTS (NP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the expected winner per output (-1 = none).
    task automatic step(input logic [0:NP-1] r0, r1, r2, r3, r4,
                        input logic [0:NP-1] tail, en, input logic rst_n,
                        input int w0, w1, w2, w3, w4, input string name);
        exp_t e;
        int   w [NP];
        @(posedge clk);
        #1;
        bus.i_output_req[0] = r0;
        bus.i_output_req[1] = r1;
        bus.i_output_req[2] = r2;
        bus.i_output_req[3] = r3;
        bus.i_output_req[4] = r4;
        bus.i_tail          = tail;
        bus.i_en            = en;
        reset_n             = rst_n;
        w       = '{w0, w1, w2, w3, w4};
        e.grant = '0;
        e.sel   = '0;
        e.val   = '0;
        e.name  = name;
        for (int o = 0; o < int'(NP); o++) begin
            if (w[o] >= 0) begin
                e.sel[o][w[o]] = 1'b1;
                e.val[o]       = 1'b1;
                e.grant[w[o]]  = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare the outputs of each driven cycle away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (bus.o_input_grant !== mon_e.grant) begin
                errors++;
                $display("FAIL %s grant: got %b want %b", mon_e.name, bus.o_input_grant, mon_e.grant);
            end
            checks++;
            if (bus.o_output_sel !== mon_e.sel) begin
                errors++;
                $display("FAIL %s sel: got %b want %b", mon_e.name, bus.o_output_sel, mon_e.sel);
            end
            checks++;
            if (bus.o_output_val !== mon_e.val) begin
                errors++;
                $display("FAIL %s val: got %b want %b", mon_e.name, bus.o_output_val, mon_e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        bus.i_output_req = '0;
        bus.i_tail       = '0;
        bus.i_en         = '0;

        step(O0, O2, O4, O1, O3, ALL, ALL, 1'b0, -1, -1, -1, -1, -1, "reset_req");
        // Single flit, then pointer on output 2 walks 2 -> 4 -> 2.
        step(NO, O2, NO, NO, NO, ALL, ALL, 1'b1, -1, -1,  1, -1, -1, "u1_to_o2");
        step(NO, O2, NO, O2, NO, ALL, ALL, 1'b1, -1, -1,  3, -1, -1, "o2_ptr2");
        step(NO, O2, NO, O2, NO, ALL, ALL, 1'b1, -1, -1,  1, -1, -1, "o2_ptr4");
        // Round robin with wrap on output 0.
        step(O0, NO, NO, O0, O0, ALL, ALL, 1'b1,  0, -1, -1, -1, -1, "rr_o0_a");
        step(O0, NO, NO, O0, O0, ALL, ALL, 1'b1,  3, -1, -1, -1, -1, "rr_o0_b");
        step(O0, NO, NO, O0, O0, ALL, ALL, 1'b1,  4, -1, -1, -1, -1, "rr_o0_c");
        step(O0, NO, NO, O0, O0, ALL, ALL, 1'b1,  0, -1, -1, -1, -1, "rr_o0_d");
        step(O0, NO, NO, O0, O0, ALL, ALL, 1'b1,  3, -1, -1, -1, -1, "rr_o0_e");
        step(5'b11000, O0, NO, NO, NO, ALL, ALL, 1'b1, 1, -1, -1, -1, -1, "multihot");
        // Wormhole packet from input 2 on output 4 against a competing input 1.
        step(NO, O4, NO, NO, NO, ALL,      ALL, 1'b1, -1, -1, -1, -1,  1, "o4_prime");
        step(NO, O4, O4, NO, NO, 5'b01000, ALL, 1'b1, -1, -1, -1, -1,  2, "pkt_f1");
        step(NO, O4, O4, NO, NO, 5'b01000, ALL, 1'b1, -1, -1, -1, -1,  2, "pkt_f2");
        step(NO, O4, O4, NO, NO, 5'b01100, ALL, 1'b1, -1, -1, -1, -1,  2, "pkt_f3");
        step(NO, O4, NO, NO, NO, 5'b01000, ALL, 1'b1, -1, -1, -1, -1,  1, "pkt_next");
        // Same packet with a bubble and two back-pressured cycles.
        step(NO, O4, O4, NO, NO, 5'b01000, ALL,      1'b1, -1, -1, -1, -1,  2, "pkt2_f1");
        step(NO, O4, NO, NO, NO, 5'b01000, ALL,      1'b1, -1, -1, -1, -1, -1, "bubble");
        step(NO, O4, O4, NO, NO, 5'b01000, ALL,      1'b1, -1, -1, -1, -1,  2, "pkt2_f2");
        step(NO, O4, O4, NO, NO, 5'b01100, 5'b11110, 1'b1, -1, -1, -1, -1, -1, "en_off_a");
        step(NO, O4, O4, NO, NO, 5'b01100, 5'b11110, 1'b1, -1, -1, -1, -1, -1, "en_off_b");
        step(NO, O4, O4, NO, NO, 5'b01100, ALL,      1'b1, -1, -1, -1, -1,  2, "en_on");
        step(NO, O4, NO, NO, NO, 5'b01000, ALL,      1'b1, -1, -1, -1, -1,  1, "pkt2_next");
        // All outputs granted in one cycle.
        step(O1, O2, O3, O4, O0, ALL, ALL, 1'b1, 4, 0, 1, 2, 3, "all_distinct");
        // Lock on output 1, reset mid-packet, restart from pointer 0.
        step(NO, NO, NO, O1, NO, NO,       ALL, 1'b1, -1,  3, -1, -1, -1, "lock_o1");
        step(NO, NO, NO, O1, O1, NO,       ALL, 1'b1, -1,  3, -1, -1, -1, "lock_o1_hold");
        step(NO, NO, NO, O1, O1, NO,       ALL, 1'b0, -1, -1, -1, -1, -1, "rst_mid");
        step(NO, NO, NO, O1, O1, NO,       ALL, 1'b1, -1,  3, -1, -1, -1, "post_rst_o1");
        step(NO, NO, NO, O1, O1, 5'b00010, ALL, 1'b1, -1,  3, -1, -1, -1, "o1_tail");
        step(NO, NO, NO, NO, O1, 5'b00001, ALL, 1'b1, -1,  4, -1, -1, -1, "o1_next");
        // Reset must drop a held lock.
        step(NO, NO, NO, O1, NO, NO,       ALL, 1'b1, -1,  3, -1, -1, -1, "relock");
        step(NO, NO, NO, O1, NO, NO,       ALL, 1'b0, -1, -1, -1, -1, -1, "rst2");
        step(NO, NO, NO, NO, O1, ALL,      ALL, 1'b1, -1,  4, -1, -1, -1, "drop_lock");
        step(NO, NO, NO, NO, NO, ALL,      ALL, 1'b1, -1, -1, -1, -1, -1, "idle_end");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enoc_switch_allocator.md
# enoc_switch_allocator

Per-router switch allocator for the ENoC router. It consumes the one-hot output-port requests produced for each input port's head flit and grants each output port to at most one input per cycle. Each output uses a round-robin arbiter and holds the grant for a whole wormhole packet until the tail flit passes. Its grants drive the input-buffer read enables and the crossbar selects.

## Interface
Parameters:
- N_PORTS, 5, number of router ports; index order [c,n,e,s,w] = 0..4.

Ports:
- clk  in  1  router clock.
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- i_output_req  in  [0:N_PORTS-1][0:N_PORTS-1]  per input port: one-hot requested output, all-zero = no request.
- i_tail  in  [0:N_PORTS-1]  per input port: the flit at the head of the input is the last flit of its packet.
- i_en  in  [0:N_PORTS-1]  per output port: downstream can accept a flit this cycle.
- o_input_grant  out  [0:N_PORTS-1]  per input port: the head flit transfers this cycle (buffer pop).
- o_output_sel  out  [0:N_PORTS-1][0:N_PORTS-1]  per output port: one-hot selected input, for the crossbar.
- o_output_val  out  [0:N_PORTS-1]  per output port: a flit is driven this cycle.

## Operation
- Each output o has two registered items: a priority pointer ptr[o] of width log2(N_PORTS), and an FSM state (IDLE or LOCKED). A LOCKED state also holds an owner index.
- Requests: input i requests output o iff i_output_req[i] is exactly one-hot with bit o set. A vector with more than one bit set counts as no request.
- IDLE:
  - Winner = first requesting input at or after ptr[o], searching cyclically with wrap N_PORTS-1 -> 0.
  - If a winner exists and i_en[o]=1: grant the winner, and set ptr[o] <= (winner+1) mod N_PORTS (wrap-around explicit for non-power-of-2).
  - If the granted flit has i_tail=0: go to LOCKED with owner = winner. If i_tail=1 (single-flit packet): stay IDLE.
  - If i_en[o]=0: no grant, and neither the pointer nor the state changes.
- LOCKED:
  - Only the owner is eligible. Grant when the owner requests o and i_en[o]=1.
  - Granted flit with i_tail=1: go to IDLE. Otherwise stay LOCKED.
  - Owner not requesting (bubble): no grant to any input, stay LOCKED.
  - The pointer does not move while LOCKED.
- Outputs:
  - o_output_sel[o] = one-hot of the granted input, else 0.
  - o_output_val[o] = |o_output_sel[o].
  - o_input_grant[i] = OR over o of o_output_sel[o][i].
  - Outputs are independent, so non-conflicting requests are all granted in the same cycle.
- U-turn requests (input i to output i) are not filtered.

## Timing
- Grant is combinational from the current requests, i_tail, i_en and the registered state. Latency is 0 cycles from request to grant.
- Pointer and FSM update on the rising clk edge in the granting cycle.
- A flit transfers in exactly the cycle where o_input_grant=1. The input buffer pops on that edge.
- Full-throughput packet: one flit per cycle per output while i_en=1 and the owner requests continuously.
- Reset (reset_n=0 at a clk edge): every ptr <= 0 and every FSM <= IDLE.
  - During any cycle with reset_n=0, all outputs are forced to 0 (o_input_grant, o_output_sel, o_output_val).
  - Reset mid-packet drops the lock. Arbitration restarts from pointer 0 in the first cycle with reset_n=1.
- Simultaneous tail grant and new requests on the same output: the new head waits for the next cycle. The IDLE arbitration then uses the pointer value from before the lock (owner+1).

## Structure
- Package enoc_alloc_pkg holds:
  - port index constants C=0, N=1, E=2, S=3, W=4;
  - the state enum {IDLE, LOCKED};
  - the log2 function.
- Sub-module enoc_rr_arbiter: a combinational N-input cyclic priority search that takes a request vector and a pointer, and returns a one-hot grant plus the winner index. It is instantiated once per output.
- The FSM, owner, pointer registers and the i_en/tail logic live in the top module, generated per output.

## Test plan
- Input 1 requests output 2 (5'b00100), i_tail=1, i_en=all 1 -> in the same cycle o_input_grant=5'b01000, o_output_sel[2]=5'b01000, o_output_val[2]=1; ptr[2] becomes 2 and the FSM stays IDLE.
- Inputs 0, 3 and 4 continuously request output 0 with single-flit packets from reset -> grants in successive cycles to 0, 3, 4, 0, 3 (wrap-around checked).
- Input 2 sends a 3-flit packet to output 4 (tail on flit 3) while input 1 also requests output 4:
  - input 2 is granted in cycles 0, 1 and 2;
  - input 1 is granted in cycle 3;
  - if the owner deasserts its request at cycle 1, there is no grant on output 4 and input 1 still waits.
- Lock held on output 4 with i_en[4]=0 for 2 cycles -> no grant, and the state and owner are unchanged. The packet resumes when i_en[4]=1.
- Five inputs each request a distinct output (0->1, 1->2, 2->3, 3->4, 4->0) -> o_input_grant=5'b11111 in one cycle.
- Input 3 is LOCKED on output 1; assert reset_n=0 for one cycle -> all outputs are 0 in that cycle. Afterwards inputs 3 and 4 both request output 1 with heads -> input 3 is granted first (ptr=0 search order).
